// File: rtl/db_arbiter_pkg.sv
// Shared data-bus encodings and arbiter-local types.
// The bus macros carry a guard so every file can see one definition.
`ifndef DATABUS_VH
`define DATABUS_VH
`define MEM_ACCESS       logic [1:0]
`define MEM_LEN          logic [1:0]
`define MEM_ACCESS_NONE  2'd0
`define MEM_ACCESS_R     2'd1
`define MEM_ACCESS_W     2'd2
`define MEM_ACCESS_X     2'd3
`endif

package db_arbiter_pkg;

   localparam int NUM_MASTERS = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   function automatic logic is_req(input logic [1:0] access_type);
      return access_type != `MEM_ACCESS_NONE;
   endfunction

endpackage

// File: rtl/db_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins.
// On a tie, the master that was not served last wins.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt,
   output logic       valid
);

   always_comb begin
      valid = |req;
      gnt   = 1'b0;
      if (req == 2'b11) begin
         gnt = ~last;
      end else if (req[1]) begin
         gnt = 1'b1;
      end
   end

endmodule

// File: rtl/db_arbiter.sv
// Two-master data-bus arbiter: master 0 is the CPU/MMU side, master 1 the DMA/debug side.
// Holds a grant until slave ready, request drop or timeout; ties are broken round-robin.
module db_arbiter
   import db_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 9
) (
   input  logic             clk,
   input  logic             res,

   input  logic [31:0]      m0_addr,
   input  logic [31:0]      m0_dataOut,
   input  `MEM_ACCESS       m0_accessType,
   input  `MEM_LEN          m0_memLen,
   input  logic             m0_io,
   output logic             m0_ready,
   output logic             m0_err,

   input  logic [31:0]      m1_addr,
   input  logic [31:0]      m1_dataOut,
   input  `MEM_ACCESS       m1_accessType,
   input  `MEM_LEN          m1_memLen,
   input  logic             m1_io,
   output logic             m1_ready,
   output logic             m1_err,

   output logic [31:0]      m_dataIn,

   output logic [31:0]      s_addr,
   output logic [31:0]      s_dataOut,
   output `MEM_ACCESS       s_accessType,
   output `MEM_LEN          s_memLen,
   output logic             s_io,
   input  logic [31:0]      s_dataIn,
   input  logic             s_ready,

   output logic             grant_id
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   // Per-master views so the forwarding path is a plain index by grant_reg.
   logic [31:0] addr_arr     [NUM_MASTERS];
   logic [31:0] data_arr     [NUM_MASTERS];
   logic [1:0]  access_arr   [NUM_MASTERS];
   logic [1:0]  len_arr      [NUM_MASTERS];
   logic        io_arr       [NUM_MASTERS];
   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] ready_vec;
   logic [NUM_MASTERS-1:0] err_vec;

   assign addr_arr[0]   = m0_addr;
   assign addr_arr[1]   = m1_addr;
   assign data_arr[0]   = m0_dataOut;
   assign data_arr[1]   = m1_dataOut;
   assign access_arr[0] = m0_accessType;
   assign access_arr[1] = m1_accessType;
   assign len_arr[0]    = m0_memLen;
   assign len_arr[1]    = m1_memLen;
   assign io_arr[0]     = m0_io;
   assign io_arr[1]     = m1_io;

   arb_state_t       state_reg;
   logic             grant_reg;
   logic             last_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic active;
   logic granted_req;
   logic done;
   logic dropped;
   logic timeout;
   logic pick_last;
   logic pick_gnt;
   logic pick_valid;

   // A reset cycle must look like IDLE on the outputs so nothing leaks out mid-abort.
   assign active      = (state_reg == ST_GRANT) && !res;
   assign granted_req = req[grant_reg];
   assign done        = active && granted_req && s_ready;
   assign dropped     = active && !granted_req;
   assign timeout     = active && granted_req && !s_ready && (cnt_reg == CNT_LAST);

   // On completion the finishing master counts as "last" already for the re-arbitration.
   assign pick_last = done ? grant_reg : last_reg;

   rr_pick2 u_pick (
      .req   (req),
      .last  (pick_last),
      .gnt   (pick_gnt),
      .valid (pick_valid)
   );

   generate
      for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
         assign req[gi]       = is_req(access_arr[gi]);
         assign ready_vec[gi] = done    && (grant_reg == 1'(gi));
         assign err_vec[gi]   = timeout && (grant_reg == 1'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (res) begin
         state_reg <= ST_IDLE;
         grant_reg <= 1'b0;
         last_reg  <= 1'b1;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               cnt_reg <= '0;
               if (pick_valid) begin
                  state_reg <= ST_GRANT;
                  grant_reg <= pick_gnt;
               end
            end
            ST_GRANT: begin
               if (done) begin
                  last_reg <= grant_reg;
                  cnt_reg  <= '0;
                  if (pick_valid) begin
                     grant_reg <= pick_gnt;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end else if (dropped) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_IDLE;
               end else if (timeout) begin
                  last_reg  <= grant_reg;
                  cnt_reg   <= '0;
                  state_reg <= ST_IDLE;
               end else if (cnt_reg != CNT_LAST) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               cnt_reg   <= '0;
            end
         endcase
      end
   end

   assign s_addr       = addr_arr[grant_reg];
   assign s_dataOut    = data_arr[grant_reg];
   assign s_memLen     = len_arr[grant_reg];
   assign s_io         = io_arr[grant_reg];
   assign s_accessType = active ? access_arr[grant_reg] : `MEM_ACCESS_NONE;

   assign m_dataIn = s_dataIn;
   assign m0_ready = ready_vec[0];
   assign m1_ready = ready_vec[1];
   assign m0_err   = err_vec[0];
   assign m1_err   = err_vec[1];
   assign grant_id = grant_reg;

endmodule

// File: tb/tb_db_arbiter.sv
// Directed bench for db_arbiter with TIMEOUT=8: one linear sequence of steps,
// each comparison an immediate assertion against a hand-computed value.
module tb_db_arbiter;

   localparam logic [1:0] ACC_NONE = 2'd0;
   localparam logic [1:0] ACC_R    = 2'd1;
   localparam logic [1:0] ACC_W    = 2'd2;

   logic        clk = 1'b0;
   logic        res;
   logic [31:0] m0_addr, m0_dataOut, m1_addr, m1_dataOut;
   logic [1:0]  m0_accessType, m0_memLen, m1_accessType, m1_memLen;
   logic        m0_io, m1_io;
   logic        m0_ready, m0_err, m1_ready, m1_err;
   logic [31:0] m_dataIn;
   logic [31:0] s_addr, s_dataOut, s_dataIn;
   logic [1:0]  s_accessType, s_memLen;
   logic        s_io, s_ready, grant_id;

   int checks = 0;
   int errors = 0;

   db_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
      .clk(clk), .res(res),
      .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_accessType(m0_accessType),
      .m0_memLen(m0_memLen), .m0_io(m0_io), .m0_ready(m0_ready), .m0_err(m0_err),
      .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_accessType(m1_accessType),
      .m1_memLen(m1_memLen), .m1_io(m1_io), .m1_ready(m1_ready), .m1_err(m1_err),
      .m_dataIn(m_dataIn),
      .s_addr(s_addr), .s_dataOut(s_dataOut), .s_accessType(s_accessType),
      .s_memLen(s_memLen), .s_io(s_io), .s_dataIn(s_dataIn), .s_ready(s_ready),
      .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      res = 1'b1;
      m0_addr = 32'h0; m0_dataOut = 32'h0; m0_accessType = ACC_NONE; m0_memLen = 2'd0; m0_io = 1'b0;
      m1_addr = 32'h0; m1_dataOut = 32'h0; m1_accessType = ACC_NONE; m1_memLen = 2'd0; m1_io = 1'b0;
      s_dataIn = 32'h0; s_ready = 1'b0;
      tick(); tick();
      settle();
      check("rst_s_access", 32'(s_accessType), 32'(ACC_NONE));
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_m0_ready", 32'(m0_ready), 32'd0);
      check("rst_m1_ready", 32'(m1_ready), 32'd0);
      check("rst_m1_err", 32'(m1_err), 32'd0);

      // Slave ready while IDLE reaches no master; read data is broadcast.
      res = 1'b0; s_ready = 1'b1; s_dataIn = 32'hDEAD_BEEF;
      settle();
      check("idle_m0_ready", 32'(m0_ready), 32'd0);
      check("idle_m1_ready", 32'(m1_ready), 32'd0);
      check("idle_dataIn", m_dataIn, 32'hDEAD_BEEF);

      // m0 read at 0x100, slave ready in grant cycle 4.
      s_ready = 1'b0;
      m0_accessType = ACC_R; m0_addr = 32'h100; m0_dataOut = 32'h1234; m0_memLen = 2'd2; m0_io = 1'b1;
      settle();
      check("t1_req_cycle_none", 32'(s_accessType), 32'(ACC_NONE));
      tick(); settle();
      check("t1_c1_access", 32'(s_accessType), 32'(ACC_R));
      check("t1_c1_addr", s_addr, 32'h100);
      check("t1_c1_dataOut", s_dataOut, 32'h1234);
      check("t1_c1_memLen", 32'(s_memLen), 32'd2);
      check("t1_c1_io", 32'(s_io), 32'd1);
      check("t1_c1_grant", 32'(grant_id), 32'd0);
      check("t1_c1_m0_ready", 32'(m0_ready), 32'd0);
      tick(); tick(); tick();
      s_ready = 1'b1; s_dataIn = 32'h0000_5A5A;
      settle();
      check("t1_c4_m0_ready", 32'(m0_ready), 32'd1);
      check("t1_c4_m1_ready", 32'(m1_ready), 32'd0);
      check("t1_c4_dataIn", m_dataIn, 32'h0000_5A5A);
      // m0 still held at the edge, so it is re-granted; dropping it now aborts silently.
      tick();
      m0_accessType = ACC_NONE;
      settle();
      check("t1_abort_access", 32'(s_accessType), 32'(ACC_NONE));
      check("t1_abort_m0_ready", 32'(m0_ready), 32'd0);
      check("t1_abort_m0_err", 32'(m0_err), 32'd0);
      s_ready = 1'b0;
      tick(); settle();
      check("t1_idle_access", 32'(s_accessType), 32'(ACC_NONE));

      // Fresh reset so master 0 wins the first tie; slave always ready.
      res = 1'b1;
      tick();
      res = 1'b0;
      m0_accessType = ACC_R; m0_addr = 32'h200;
      m1_accessType = ACC_W; m1_addr = 32'h300;
      s_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick(); settle();
         check($sformatf("t2_g%0d_grant", k), 32'(grant_id), 32'(k % 2));
         check($sformatf("t2_g%0d_access", k), 32'(s_accessType), (k % 2 == 0) ? 32'(ACC_R) : 32'(ACC_W));
         check($sformatf("t2_g%0d_addr", k), s_addr, (k % 2 == 0) ? 32'h200 : 32'h300);
         check($sformatf("t2_g%0d_m0_ready", k), 32'(m0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("t2_g%0d_m1_ready", k), 32'(m1_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      end
      tick();
      m0_accessType = ACC_NONE; m1_accessType = ACC_NONE; s_ready = 1'b0;
      settle();
      check("t2_drop_m0_ready", 32'(m0_ready), 32'd0);
      tick();

      // m1 write, slave silent: err in grant cycle 8; m0 arrives meanwhile.
      m1_accessType = ACC_W; m1_addr = 32'h400;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 3) begin
            m0_accessType = ACC_R; m0_addr = 32'h500;
         end
         settle();
         check($sformatf("t3_c%0d_access", k), 32'(s_accessType), 32'(ACC_W));
         check($sformatf("t3_c%0d_m1_err", k), 32'(m1_err), 32'd0);
      end
      tick(); settle();
      check("t3_c8_m1_err", 32'(m1_err), 32'd1);
      check("t3_c8_m0_err", 32'(m0_err), 32'd0);
      check("t3_c8_m1_ready", 32'(m1_ready), 32'd0);
      tick();
      m1_accessType = ACC_NONE;
      settle();
      check("t3_c9_access", 32'(s_accessType), 32'(ACC_NONE));
      check("t3_c9_m1_err", 32'(m1_err), 32'd0);
      check("t3_c9_grant", 32'(grant_id), 32'd1);
      tick();
      s_ready = 1'b1;
      settle();
      check("t3_m0_grant", 32'(grant_id), 32'd0);
      check("t3_m0_addr", s_addr, 32'h500);
      check("t3_m0_ready", 32'(m0_ready), 32'd1);

      // m0 still held: re-granted, slave ready lands exactly on the timeout cycle.
      tick();
      s_ready = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         settle();
         check($sformatf("t4_c%0d_m0_ready", k), 32'(m0_ready), 32'd0);
         check($sformatf("t4_c%0d_m0_err", k), 32'(m0_err), 32'd0);
         tick();
      end
      s_ready = 1'b1;
      settle();
      check("t4_c8_m0_ready", 32'(m0_ready), 32'd1);
      check("t4_c8_m0_err", 32'(m0_err), 32'd0);
      tick();
      m0_accessType = ACC_NONE; s_ready = 1'b0;
      tick();

      // Reset in the middle of a grant aborts without ready or err.
      m0_accessType = ACC_R; m0_addr = 32'h700;
      tick(); settle();
      check("t5_grant_access", 32'(s_accessType), 32'(ACC_R));
      res = 1'b1; s_ready = 1'b1;
      settle();
      check("t5_res_m0_ready", 32'(m0_ready), 32'd0);
      check("t5_res_m0_err", 32'(m0_err), 32'd0);
      check("t5_res_access", 32'(s_accessType), 32'(ACC_NONE));
      tick();
      res = 1'b0; s_ready = 1'b0; m0_accessType = ACC_NONE;
      settle();
      check("t5_after_access", 32'(s_accessType), 32'(ACC_NONE));
      check("t5_after_grant", 32'(grant_id), 32'd0);
      m1_accessType = ACC_W; m1_addr = 32'h600;
      tick();
      s_ready = 1'b1; s_dataIn = 32'hCAFE_0001;
      settle();
      check("t5_m1_grant", 32'(grant_id), 32'd1);
      check("t5_m1_access", 32'(s_accessType), 32'(ACC_W));
      check("t5_m1_addr", s_addr, 32'h600);
      check("t5_m1_ready", 32'(m1_ready), 32'd1);
      check("t5_m0_ready_nongranted", 32'(m0_ready), 32'd0);
      check("t5_dataIn", m_dataIn, 32'hCAFE_0001);
      tick();
      m1_accessType = ACC_NONE; s_ready = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
